// File: rtl/pong_frame_sequencer.sv
// pong_frame_sequencer
// Per-frame game-update scheduler for the two-player Pong core. Each 60 Hz
// refresh tick runs three update units in a fixed order over a req/done
// handshake (paddle update, ball move, collision check). It then applies the
// collision result to the scores and tracks game-over. Ticks that arrive
// mid-frame are dropped and counted. A stage that holds req for TIMEOUT cycles
// without done is abandoned and flagged.
//
// Optional build macro: PONG_SEQ_PAUSE_EN
//   defined   : pause=1 while IDLE makes refr_tick ignored (no frame, no overrun)
//   undefined : pause input is unused
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for refr_tick; new_game clears scores here
// PAD   | pad_req high, waiting for pad_done or stage timeout
// BALL  | ball_req high, waiting for ball_done or stage timeout
// COLL  | coll_req high, waiting for coll_done; captures coll_scored
// SCORE | one cycle: apply scores, bump frame_cnt, check for a win
// OVER  | game_over high; only new_game or rst leave this state

module pong_frame_sequencer #(
    parameter int unsigned TIMEOUT   = 1000000,
    parameter int unsigned WIN_SCORE = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        refr_tick,
    input  logic        new_game,
    input  logic        pause,
    output logic        pad_req,
    input  logic        pad_done,
    output logic        ball_req,
    input  logic        ball_done,
    output logic        coll_req,
    input  logic        coll_done,
    input  logic [1:0]  coll_scored,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        game_over,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [7:0]  overrun_cnt,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PAD   = 3'd1,
        S_BALL  = 3'd2,
        S_COLL  = 3'd3,
        S_SCORE = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    // The timer counts from 0; the cycle on which it holds TIMEOUT-1 without
    // done is the TIMEOUT-th req cycle, so req is dropped right after it.
    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT - 1);
    localparam logic [3:0]  WIN      = 4'(WIN_SCORE);

    state_t      state_q;
    logic        pad_req_q;
    logic        ball_req_q;
    logic        coll_req_q;
    logic        busy_q;
    logic        game_over_q;
    logic        timeout_err_q;
    logic [3:0]  score_l_q;
    logic [3:0]  score_r_q;
    logic [15:0] frame_cnt_q;
    logic [7:0]  overrun_cnt_q;
    logic [7:0]  overrun_cnt_d;
    logic [23:0] timer_q;
    logic [1:0]  scored_q;

    logic        pause_hold;
    logic        in_frame;
    logic        timer_hit;
    logic [3:0]  score_l_nx;
    logic [3:0]  score_r_nx;
    logic        win_hit;

`ifdef PONG_SEQ_PAUSE_EN
    assign pause_hold = pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign pause_hold   = 1'b0;
`endif

    // Frame-progress decode, timer terminal count and the score arithmetic
    // used by the single SCORE cycle.
    always_comb begin
        in_frame   = (state_q != S_IDLE) && (state_q != S_OVER);
        timer_hit  = (timer_q == TMO_LAST);
        score_l_nx = score_l_q + {3'b000, scored_q[0]};
        score_r_nx = score_r_q + {3'b000, scored_q[1]};
        win_hit    = (score_l_nx >= WIN) || (score_r_nx >= WIN);
    end

    // A tick that lands while a frame is in flight is dropped and counted,
    // saturating so a long stall cannot wrap the count back to a small value.
    always_comb begin
        overrun_cnt_d = overrun_cnt_q;
        if (refr_tick && in_frame && (overrun_cnt_q != 8'hFF)) begin
            overrun_cnt_d = overrun_cnt_q + 8'd1;
        end
    end

    // Overrun counter register; cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_cnt_q <= '0;
        end else begin
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    // Frame sequencer: state, stage requests, stage timer, scores and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pad_req_q     <= 1'b0;
            ball_req_q    <= 1'b0;
            coll_req_q    <= 1'b0;
            busy_q        <= 1'b0;
            game_over_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            score_l_q     <= '0;
            score_r_q     <= '0;
            frame_cnt_q   <= '0;
            timer_q       <= '0;
            scored_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (new_game) begin
                        score_l_q <= '0;
                        score_r_q <= '0;
                    end else if (refr_tick && !pause_hold) begin
                        state_q   <= S_PAD;
                        pad_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end

                S_PAD: begin
                    if (pad_done) begin
                        pad_req_q  <= 1'b0;
                        ball_req_q <= 1'b1;
                        timer_q    <= '0;
                        state_q    <= S_BALL;
                    end else if (timer_hit) begin
                        pad_req_q     <= 1'b0;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        timer_q       <= '0;
                        state_q       <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 24'd1;
                    end
                end

                S_BALL: begin
                    if (ball_done) begin
                        ball_req_q <= 1'b0;
                        coll_req_q <= 1'b1;
                        timer_q    <= '0;
                        state_q    <= S_COLL;
                    end else if (timer_hit) begin
                        ball_req_q    <= 1'b0;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        timer_q       <= '0;
                        state_q       <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 24'd1;
                    end
                end

                S_COLL: begin
                    if (coll_done) begin
                        coll_req_q <= 1'b0;
                        scored_q   <= coll_scored;
                        timer_q    <= '0;
                        state_q    <= S_SCORE;
                    end else if (timer_hit) begin
                        coll_req_q    <= 1'b0;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        timer_q       <= '0;
                        state_q       <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 24'd1;
                    end
                end

                S_SCORE: begin
                    score_l_q   <= score_l_nx;
                    score_r_q   <= score_r_nx;
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                    busy_q      <= 1'b0;
                    if (win_hit) begin
                        game_over_q <= 1'b1;
                        state_q     <= S_OVER;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_OVER: begin
                    if (new_game) begin
                        score_l_q   <= '0;
                        score_r_q   <= '0;
                        game_over_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    pad_req_q  <= 1'b0;
                    ball_req_q <= 1'b0;
                    coll_req_q <= 1'b0;
                    busy_q     <= 1'b0;
                    timer_q    <= '0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign pad_req     = pad_req_q;
    assign ball_req    = ball_req_q;
    assign coll_req    = coll_req_q;
    assign busy        = busy_q;
    assign game_over   = game_over_q;
    assign timeout_err = timeout_err_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule

// File: doc/pong_frame_sequencer.md
Name: pong_frame_sequencer

Overview:
- Per-frame game-update scheduler for the 2-player Pong design.
- Consumes the 60 Hz refresh tick and runs three update units in fixed order over a req/done handshake: paddle update, ball move, collision check.
- Applies score results and tracks game-over.
- Detects frame overruns and hung stages; exposes frame count and status to display/debug logic.

Parameters:
- TIMEOUT, 1000000, max cycles a stage may hold req without done; range 1..2^24-1.
- WIN_SCORE, 7, score value that ends the game; range 1..15.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- refr_tick  in  1  one-cycle pulse at 60 Hz from the refresh tick generator
- new_game  in  1  level; clears scores, leaves game-over
- pause  in  1  level; used only with PAUSE_EN
- pad_req  out  1  paddle-update request
- pad_done  in  1  paddle-update done
- ball_req  out  1  ball-move request
- ball_done  in  1  ball-move done
- coll_req  out  1  collision-check request
- coll_done  in  1  collision-check done
- coll_scored  in  2  [0]=left scored, [1]=right scored; valid only with coll_done
- score_l  out  4  left score
- score_r  out  4  right score
- game_over  out  1  high while in OVER
- busy  out  1  high in any state other than IDLE/OVER
- frame_cnt  out  16  completed-frame count
- overrun_cnt  out  8  dropped-tick count
- timeout_err  out  1  sticky stage-timeout flag

Behaviour:
- Reset: all outputs 0; state IDLE; stage timer 0. rst overrides everything, including mid-frame; any req drops on the cycle after rst is sampled.
- States: IDLE, PAD, BALL, COLL, SCORE, OVER. All outputs are registered.
- IDLE: refr_tick=1 moves to PAD next cycle, so pad_req=1 at tick+1.
- new_game=1 in IDLE or OVER: clears score_l and score_r, moves to IDLE. new_game has priority over refr_tick in the same cycle. Ignored in all other states.
- Handshake: req rises on entry to its stage and is held until done=1 is sampled.
  - Next stage's req is high the cycle after done; the current req is low that same cycle.
  - done while the matching req is low is ignored.
  - Zero-wait done, i.e. done=1 on the first req cycle, is legal.
  - Best-case frame: tick at t, pad_req t+1..t+1, ball_req t+2, coll_req t+3, SCORE t+4, IDLE t+5.
- COLL: on coll_done, capture coll_scored.
- SCORE: one cycle.
  - Increment score_l if bit0, score_r if bit1; both may increment together.
  - frame_cnt+1, wrapping 65535 to 0.
  - If either new score is at least WIN_SCORE, go to OVER; else go to IDLE.
- OVER: game_over=1. refr_tick is ignored and not counted as an overrun. Exit only via new_game or rst.
- Overrun: refr_tick=1 in any state other than IDLE/OVER drops the tick (it is not queued) and increments overrun_cnt, saturating at 255. A tick in the SCORE cycle is an overrun.
- Timeout: stage timer clears on stage entry and counts each cycle req is high without done.
  - When the timer reaches TIMEOUT: drop req, set timeout_err, return to IDLE.
  - Scores and frame_cnt are unchanged.
  - done arriving in the same cycle as the timer reaching TIMEOUT wins; no timeout occurs.
- timeout_err and overrun_cnt are cleared only by rst.

Optional Feature:
- Macro: PONG_SEQ_PAUSE_EN.
- Defined: pause=1 while in IDLE makes refr_tick ignored. The tick does not start a frame and is not counted as an overrun. pause is ignored mid-frame; the frame in progress completes normally.
- Undefined: pause input is unused, and behaviour is exactly as described above.

Test Plan:
- Zero-wait frame: rst, then tick with all done tied high -> pad/ball/coll_req each high exactly 1 cycle at t+1/t+2/t+3; frame_cnt=1; busy high t+1..t+4.
- Delayed done: pad_done 5 cycles after pad_req rises -> pad_req high exactly 5 cycles; ball_req rises the cycle after pad_done.
- Overrun: second tick while ball_req is pending -> overrun_cnt=1, frame completes once, frame_cnt=1. 300 overrun ticks -> overrun_cnt=255.
- Timeout: TIMEOUT=16, coll_done held low -> coll_req drops after 16 cycles; timeout_err=1; state IDLE; scores unchanged; next tick starts a new frame.
- Scoring/win: WIN_SCORE=3, coll_scored=2'b11 for 3 frames -> scores 1,2,3; game_over=1 after frame 3; further ticks ignored with overrun_cnt unchanged; new_game -> scores 0, game_over 0.
- Reset mid-frame, plus pause with PONG_SEQ_PAUSE_EN: rst during BALL -> all outputs 0 next cycle. pause=1 in IDLE plus tick -> no pad_req and overrun_cnt unchanged.
